// File: rtl/gate_op_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gate_op_arbiter_if
// Purpose  : Requester/result bundle between two requesters and the arbiter.
//            GATE_ARB_STATS_EN adds the cnt0/cnt1/busy statistics signals.
// Revision : 1.0 - initial release
// ============================================================================
interface gate_op_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [2:0]       op0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [2:0]       op1;
    logic [1:0]       grant;
    logic [1:0]       ack;
    logic [WIDTH-1:0] res;
    logic             res_valid;
    logic             res_id;
    logic             op_err;
`ifdef GATE_ARB_STATS_EN
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;
    logic             busy;
`endif

`ifdef GATE_ARB_STATS_EN
    modport master (
        output req, a0, b0, op0, a1, b1, op1,
        input  grant, ack, res, res_valid, res_id, op_err, cnt0, cnt1, busy
    );
    modport slave (
        input  req, a0, b0, op0, a1, b1, op1,
        output grant, ack, res, res_valid, res_id, op_err, cnt0, cnt1, busy
    );
`else
    modport master (
        output req, a0, b0, op0, a1, b1, op1,
        input  grant, ack, res, res_valid, res_id, op_err
    );
    modport slave (
        input  req, a0, b0, op0, a1, b1, op1,
        output grant, ack, res, res_valid, res_id, op_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gate_op_arbiter
// Purpose  : Round-robin sharing of one bitwise gate unit between two
//            requesters. Optional statistics via GATE_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gate_op_arbiter #(
    parameter int WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    gate_op_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             id_q, id_d;
    logic [1:0]       grant_q, grant_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_id_q, res_id_d;
    logic             err_q, err_d;
    logic             w_sel;
    logic [WIDTH-1:0] w_gate;
    logic             w_illegal;
    logic             w_done;

    always_comb begin
        w_gate    = '0;
        w_illegal = 1'b0;
        case (op_q)
            3'd0:    w_gate = a_q & b_q;
            3'd1:    w_gate = a_q | b_q;
            3'd2:    w_gate = ~a_q;
            3'd3:    w_gate = a_q ^ b_q;
            3'd4:    w_gate = ~(a_q & b_q);
            3'd5:    w_gate = ~(a_q | b_q);
            default: w_illegal = 1'b1;
        endcase
    end

    // On a tie the requester that was not served last wins.
    assign w_sel = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        grant_d  = grant_q;
        res_d    = res_q;
        res_id_d = res_id_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    a_d     = w_sel ? bus.a1  : bus.a0;
                    b_d     = w_sel ? bus.b1  : bus.b0;
                    op_d    = w_sel ? bus.op1 : bus.op0;
                    id_d    = w_sel;
                    grant_d = w_sel ? 2'b10 : 2'b01;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d    = w_gate;
                err_d    = w_illegal;
                res_id_d = id_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                last_d  = res_id_q;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 3'd0;
            id_q     <= 1'b0;
            grant_q  <= 2'b00;
            res_q    <= '0;
            res_id_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            grant_q  <= grant_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
            err_q    <= err_d;
        end
    end

    assign w_done        = (state_q == S_DONE);
    assign bus.grant     = grant_q;
    assign bus.res       = res_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = w_done;
    assign bus.ack       = w_done ? (res_id_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.op_err    = w_done & err_q;

`ifdef GATE_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else if (w_done) begin
            if (res_id_q) cnt1_q <= cnt1_q + 8'd1;
            else          cnt0_q <= cnt0_q + 8'd1;
        end
    end

    assign bus.cnt0 = cnt0_q;
    assign bus.cnt1 = cnt1_q;
    assign bus.busy = (state_q == S_EXEC) || w_done;
`endif
endmodule
`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_op_arbiter
// Purpose  : Directed vector bench for gate_op_arbiter (stats checks only
//            when GATE_ARB_STATS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_op_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    gate_op_arbiter_if #(.WIDTH(4)) bus ();

    gate_op_arbiter #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [2:0] op0;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [2:0] op1;
        logic [3:0] exp_res;
        logic       exp_err;
        logic       exp_id;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 2'b00;
        step();
        rst     = 1'b0;
    endtask

    // Issue one transaction; operands are scrambled right after acceptance.
    task automatic run_vec(input vec_t v);
        logic [1:0] g;
        g = v.exp_id ? 2'b10 : 2'b01;
        bus.req = v.req;
        bus.a0 = v.a0; bus.b0 = v.b0; bus.op0 = v.op0;
        bus.a1 = v.a1; bus.b1 = v.b1; bus.op1 = v.op1;
        step();
        chk("exec_grant", 32'(bus.grant), 32'(g));
        chk("exec_valid", 32'(bus.res_valid), 32'd0);
        bus.a0 = ~v.a0; bus.b0 = ~v.b0; bus.op0 = v.op0 ^ 3'd1;
        bus.a1 = ~v.a1; bus.b1 = ~v.b1; bus.op1 = v.op1 ^ 3'd1;
        step();
        chk("done_res",   32'(bus.res), 32'(v.exp_res));
        chk("done_valid", 32'(bus.res_valid), 32'd1);
        chk("done_ack",   32'(bus.ack), 32'(g));
        chk("done_id",    32'(bus.res_id), 32'(v.exp_id));
        chk("done_err",   32'(bus.op_err), 32'(v.exp_err));
        chk("done_grant", 32'(bus.grant), 32'(g));
        bus.req = 2'b00;
        step();
        chk("idle_valid", 32'(bus.res_valid), 32'd0);
        chk("idle_ack",   32'(bus.ack), 32'd0);
        chk("idle_grant", 32'(bus.grant), 32'd0);
        chk("idle_err",   32'(bus.op_err), 32'd0);
        chk("idle_res",   32'(bus.res), 32'(v.exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        //          req    a0    b0    op0   a1    b1    op1   res   err   id
        vecs[0] = '{2'b01, 4'hC, 4'hA, 3'd3, 4'h0, 4'h0, 3'd0, 4'h6, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 4'h5, 4'hF, 3'd2, 4'h0, 4'h0, 3'd0, 4'hA, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 4'h5, 4'hF, 3'd7, 4'h0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{2'b10, 4'h0, 4'h0, 3'd0, 4'hF, 4'h3, 3'd4, 4'hC, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 4'h0, 4'h0, 3'd0, 4'hC, 4'hA, 3'd0, 4'h8, 1'b0, 1'b1};
        vecs[5] = '{2'b01, 4'hC, 4'hA, 3'd1, 4'h0, 4'h0, 3'd0, 4'hE, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 4'h0, 4'h0, 3'd0, 4'hC, 4'hA, 3'd5, 4'h1, 1'b0, 1'b1};
        vecs[7] = '{2'b01, 4'h9, 4'h3, 3'd6, 4'h0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0};
        vecs[8] = '{2'b11, 4'h3, 4'h5, 3'd3, 4'h3, 4'h5, 3'd0, 4'h1, 1'b0, 1'b1};
        vecs[9] = '{2'b11, 4'h3, 4'h5, 3'd1, 4'h3, 4'h5, 3'd3, 4'h7, 1'b0, 1'b0};

        rst = 1'b1;
        bus.req = 2'b00;
        bus.a0 = 4'h0; bus.b0 = 4'h0; bus.op0 = 3'd0;
        bus.a1 = 4'h0; bus.b1 = 4'h0; bus.op1 = 3'd0;
        step();
        step();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack",   32'(bus.ack), 32'd0);
        chk("rst_res",   32'(bus.res), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_id",    32'(bus.res_id), 32'd0);
        chk("rst_err",   32'(bus.op_err), 32'd0);
        rst = 1'b0;

        // Tie right after reset: requester 0 first, requester 1 three cycles later.
        bus.req = 2'b11;
        bus.a0 = 4'hC; bus.b0 = 4'hA; bus.op0 = 3'd3;
        bus.a1 = 4'hF; bus.b1 = 4'h3; bus.op1 = 3'd4;
        step();
        chk("tie_grant0", 32'(bus.grant), 32'b01);
        step();
        chk("tie_ack0", 32'(bus.ack), 32'b01);
        chk("tie_res0", 32'(bus.res), 32'h6);
        bus.req = 2'b10;
        step();
        chk("tie_gap_ack", 32'(bus.ack), 32'd0);
        step();
        chk("tie_grant1", 32'(bus.grant), 32'b10);
        chk("tie_gap_valid", 32'(bus.res_valid), 32'd0);
        step();
        chk("tie_ack1", 32'(bus.ack), 32'b10);
        chk("tie_res1", 32'(bus.res), 32'hC);
        chk("tie_id1",  32'(bus.res_id), 32'd1);
        bus.req = 2'b00;
        step();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset while in EXEC abandons the operation.
        bus.req = 2'b01; bus.a0 = 4'hF; bus.b0 = 4'hF; bus.op0 = 3'd0;
        step();
        chk("mid_grant", 32'(bus.grant), 32'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 2'b00;
        chk("mid_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_ack",   32'(bus.ack), 32'd0);
        chk("mid_grant0", 32'(bus.grant), 32'd0);
        chk("mid_res",   32'(bus.res), 32'd0);
        chk("mid_id",    32'(bus.res_id), 32'd0);
        chk("mid_err",   32'(bus.op_err), 32'd0);
        step();
        chk("mid_after_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_after_ack",   32'(bus.ack), 32'd0);

`ifdef GATE_ARB_STATS_EN
        do_reset();
        chk("st_cnt0_rst", 32'(bus.cnt0), 32'd0);
        chk("st_busy_idle", 32'(bus.busy), 32'd0);
        run_vec(vecs[0]);
        chk("st_cnt0_one", 32'(bus.cnt0), 32'd1);
        for (int i = 1; i < 256; i++) run_vec(vecs[0]);
        chk("st_cnt0_wrap", 32'(bus.cnt0), 32'd0);
        chk("st_cnt1_zero", 32'(bus.cnt1), 32'd0);
        bus.req = 2'b01;
        step();
        chk("st_busy_exec", 32'(bus.busy), 32'd1);
        bus.req = 2'b00;
        step();
        chk("st_busy_done", 32'(bus.busy), 32'd1);
        step();
`else
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gate_op_arbiter.md
Name: gate_op_arbiter

Overview:
- Shares one WIDTH-bit bitwise gate unit (AND, OR, NOT, XOR, NAND, NOR) between two requesters.
- Arbitration is round-robin.
- Each accepted request is sequenced through a 3-state FSM. The registered result is returned with a one-cycle valid/ack pulse to the winning requester.
- Sits between requester logic and the shared logic datapath. It is the only path by which the datapath is driven.

Parameters:
WIDTH, 4, operand and result width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  2  request per requester; bit i = requester i; held high until ack[i]
a0  input  WIDTH  operand A, requester 0
b0  input  WIDTH  operand B, requester 0
op0  input  3  opcode, requester 0
a1  input  WIDTH  operand A, requester 1
b1  input  WIDTH  operand B, requester 1
op1  input  3  opcode, requester 1
grant  output  2  one-hot; bit of the requester being served, held from EXEC through DONE
ack  output  2  one-hot single-cycle pulse in DONE to the served requester
res  output  WIDTH  result register
res_valid  output  1  high for exactly the DONE cycle
res_id  output  1  index of the requester that owns res
op_err  output  1  high with res_valid when the latched opcode was illegal

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - grant=0, ack=0, res=0, res_valid=0, res_id=0, op_err=0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
- Opcodes: 0 AND, 1 OR, 2 NOT a (b ignored), 3 XOR, 4 NAND, 5 NOR.
  - Opcodes 6 and 7 are illegal: res=0 and op_err=1.
  - All operations are bitwise over WIDTH bits.
- IDLE:
  - If req==0, stay in IDLE.
  - If exactly one req bit is set, select that requester.
  - If req==2'b11, select the requester not equal to the last-served pointer.
  - On selection: latch that requester's a, b, op and id into internal registers; set grant; go to EXEC.
- EXEC (1 cycle):
  - Compute the gate function from the latched operands.
  - Register the result into res and op_err; set res_id.
  - Go to DONE.
- DONE (1 cycle):
  - res_valid=1 and ack[res_id]=1.
  - Update the last-served pointer to res_id.
  - Go to IDLE; clear grant on that transition.
- Timing:
  - Latency: req sampled in cycle N gives res_valid/ack in cycle N+2.
  - Next arbitration happens in cycle N+3.
  - Maximum throughput is one operation per 3 cycles.
- Operand stability: operands are sampled only in IDLE. Changes to a/b/op after acceptance do not affect the in-flight result.
- Requester rule: deassert req in the cycle after ack. If req is still high in IDLE, it is treated as a new request.
- A req bit dropped before it is accepted is simply not served. No error is raised.
- Outputs outside DONE: res and res_id hold their last values. res_valid, ack and op_err are 0.
- Reset asserted in any state: the in-flight operation is abandoned and no ack is issued. All outputs take reset values on the next edge.

Optional Feature:
- Macro: GATE_ARB_STATS_EN.
- When defined:
  - Adds outputs cnt0 and cnt1 (8 bits each), counting DONE cycles per requester.
  - Counters wrap 255 to 0 and are cleared by rst.
  - Adds output busy (1 bit), high in EXEC and DONE.
- When not defined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset → all outputs 0; the first tie is granted to requester 0.
- req=01, a0=4'b1100, b0=4'b1010, op0=3 (XOR) accepted in cycle N → res=4'b0110, res_valid=1, ack=01, res_id=0 in cycle N+2; grant=01 in cycles N+1 and N+2.
- req=11 held, both requesters deassert after their own ack:
  - Grant order is 0, then 1.
  - ack pulses are 3 cycles apart.
  - Check op1=4 (NAND) with a1=4'hF, b1=4'h3 gives res=4'hC.
- op0=2 (NOT), a0=4'b0101, b0=4'hF → res=4'b1010. Then op0=7 → res=0, op_err=1 for one cycle.
- Operand change: alter a0 in cycle N+1 after acceptance → res reflects the cycle-N value.
- Reset mid-operation: assert rst in EXEC → no ack and no res_valid; next cycle is IDLE and all outputs are 0.
- With GATE_ARB_STATS_EN: 256 requester-0 completions → cnt0 wraps to 0 and cnt1 stays 0.
